// File: rtl/sobel_window3x3.sv
// sobel_window3x3: raster-scan 3x3 neighbourhood generator feeding the Sobel stage.
// Two line buffers hold the previous two image rows; a 3x3 register window
// shifts left on every accepted pixel. win_valid qualifies only windows whose
// nine taps all lie inside the current frame.
//
// Handshake: there is no backpressure. A pixel is accepted on every rising
// clock edge where pix_valid=1; sof is meaningful only on those edges.
// win_valid and frame_done are single-cycle qualifiers registered one edge
// after the pixel that produced them, and are 0 after any idle cycle.
module sobel_window3x3 #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pix_in,
  input  logic       pix_valid,
  input  logic       sof,
  output logic [7:0] z1,
  output logic [7:0] z2,
  output logic [7:0] z3,
  output logic [7:0] z4,
  output logic [7:0] z5,
  output logic [7:0] z6,
  output logic [7:0] z7,
  output logic [7:0] z8,
  output logic [7:0] z9,
  output logic       win_valid,
  output logic       frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0] col_q, col_d, col_cur;
  logic [RW-1:0] row_q, row_d, row_cur;
  logic          last_col, last_row;

  // Line buffers: lb1 holds row r-1, lb2 holds row r-2 (not reset).
  logic [7:0] lb1_q [IMG_W];
  logic [7:0] lb2_q [IMG_W];
  logic [7:0] lb_a, lb_b;

  // Window taps, index 0..8 maps to z1..z9 in row-major order.
  logic [7:0] z_q [9];
  logic [7:0] z_d [9];

  logic win_valid_q, win_valid_d;
  logic frame_done_q, frame_done_d;

  // sof forces the accepted pixel to (0,0) regardless of the counters.
  assign col_cur  = sof ? '0 : col_q;
  assign row_cur  = sof ? '0 : row_q;
  assign last_col = (col_cur == CW'(IMG_W - 1));
  assign last_row = (row_cur == RW'(IMG_H - 1));
  assign lb_a     = lb1_q[col_cur];
  assign lb_b     = lb2_q[col_cur];

  // Next-state: raster counters, window shift and output qualifiers.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    z_d          = z_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    if (pix_valid) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_cur + RW'(1);
      end else begin
        col_d = col_cur + CW'(1);
        row_d = row_cur;
      end
      z_d[0] = z_q[1];
      z_d[1] = z_q[2];
      z_d[2] = lb_b;
      z_d[3] = z_q[4];
      z_d[4] = z_q[5];
      z_d[5] = lb_a;
      z_d[6] = z_q[7];
      z_d[7] = z_q[8];
      z_d[8] = pix_in;
      win_valid_d  = (row_cur >= RW'(2)) && (col_cur >= CW'(2));
      frame_done_d = last_row && last_col;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q        <= '0;
      row_q        <= '0;
      z_q          <= '{default: 8'h00};
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      z_q          <= z_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line-buffer update: push the column down one row, store the new pixel.
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb2_q[col_cur] <= lb_a;
      lb1_q[col_cur] <= pix_in;
    end
  end

  assign z1         = z_q[0];
  assign z2         = z_q[1];
  assign z3         = z_q[2];
  assign z4         = z_q[3];
  assign z5         = z_q[4];
  assign z6         = z_q[5];
  assign z7         = z_q[6];
  assign z8         = z_q[7];
  assign z9         = z_q[8];
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sobel_window3x3.sv
// tb_sobel_window3x3: directed frames on a 5x4 image through sobel_window3x3.
module tb_sobel_window3x3;

  localparam int W = 5;
  localparam int H = 4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] pix_in = 8'h00;
  logic       pix_valid = 1'b0;
  logic       sof = 1'b0;
  logic [7:0] z1, z2, z3, z4, z5, z6, z7, z8, z9;
  logic       win_valid, frame_done;
  logic [71:0] taps;

  always #5 clk = ~clk;

  assign taps = {z1, z2, z3, z4, z5, z6, z7, z8, z9};

  sobel_window3x3 #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .reset(reset), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
    .z1(z1), .z2(z2), .z3(z3), .z4(z4), .z5(z5), .z6(z6), .z7(z7), .z8(z8), .z9(z9),
    .win_valid(win_valid), .frame_done(frame_done)
  );

  // ---------------- scoreboard state ----------------
  logic [71:0] exp_q[$];
  logic [71:0] hold_taps;
  logic [71:0] first_win;
  logic [7:0]  img [H][W];
  bit          exp_wv, exp_fd, exp_hold, first_seen;
  int          m_row, m_col;
  int          win_cnt, fd_cnt;
  int          n_vec, n_bad;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare registered outputs against the expectation set up last cycle.
  task automatic observe();
    check("win_valid", {71'd0, win_valid}, {71'd0, exp_wv});
    check("frame_done", {71'd0, frame_done}, {71'd0, exp_fd});
    if (win_valid) win_cnt++;
    if (frame_done) fd_cnt++;
    if (win_valid && !first_seen) begin
      first_win  = taps;
      first_seen = 1'b1;
    end
    if (exp_wv) begin
      if (exp_q.size() == 0) check("exp_q_empty", 72'd1, 72'd0);
      else check("taps", taps, exp_q.pop_front());
    end else if (exp_hold) begin
      check("taps_hold", taps, hold_taps);
    end
  endtask

  // Reference model: track the raster position and the current frame image.
  task automatic predict(input bit pv, input bit s, input logic [7:0] px);
    logic [71:0] w;
    exp_wv = 1'b0;
    exp_fd = 1'b0;
    if (pv) begin
      if (s) begin
        m_row = 0;
        m_col = 0;
      end
      img[m_row][m_col] = px;
      if (m_row >= 2 && m_col >= 2) begin
        w = {img[m_row-2][m_col-2], img[m_row-2][m_col-1], img[m_row-2][m_col],
             img[m_row-1][m_col-2], img[m_row-1][m_col-1], img[m_row-1][m_col],
             img[m_row][m_col-2],   img[m_row][m_col-1],   img[m_row][m_col]};
        exp_q.push_back(w);
        exp_wv    = 1'b1;
        hold_taps = w;
        exp_hold  = 1'b1;
      end else begin
        exp_hold = 1'b0;
      end
      exp_fd = (m_row == H - 1) && (m_col == W - 1);
      if (m_col == W - 1) begin
        m_col = 0;
        m_row = (m_row == H - 1) ? 0 : m_row + 1;
      end else begin
        m_col++;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit pv, input bit s, input logic [7:0] px);
    @(negedge clk);
    observe();
    pix_valid = pv;
    sof       = s;
    pix_in    = px;
    predict(pv, s, px);
  endtask

  task automatic start_phase();
    win_cnt    = 0;
    fd_cnt     = 0;
    first_seen = 1'b0;
  endtask

  task automatic send_pixels(input int base, input int n, input bit use_sof, input bit gaps);
    for (int i = 0; i < n; i++) begin
      step(1'b1, use_sof && (i == 0), 8'(base + 10 * (i / W) + (i % W)));
      if (gaps) step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    observe();
    pix_valid = 1'b0;
    sof       = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("rst_taps", taps, 72'd0);
    check("rst_win_valid", {71'd0, win_valid}, 72'd0);
    check("rst_frame_done", {71'd0, frame_done}, 72'd0);
    exp_q.delete();
    m_row     = 0;
    m_col     = 0;
    exp_wv    = 1'b0;
    exp_fd    = 1'b0;
    exp_hold  = 1'b1;
    hold_taps = 72'd0;
    @(negedge clk);
    observe();
    #1 reset = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    n_vec = 0;
    n_bad = 0;
    m_row = 0;
    m_col = 0;
    exp_wv = 1'b0;
    exp_fd = 1'b0;
    exp_hold = 1'b1;
    hold_taps = 72'd0;
    start_phase();
    #3;
    check("por_taps", taps, 72'd0);
    reset = 1'b1;
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);

    // Continuous frame, no sof: first pixel after reset is (0,0).
    start_phase();
    send_pixels(0, W * H, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00);
    check("cont_first_win", first_win, 72'h00_01_02_0a_0b_0c_14_15_16);
    check("cont_win_cnt", 72'(win_cnt), 72'd6);
    check("cont_fd_cnt", 72'(fd_cnt), 72'd1);

    // Same frame with a bubble after every pixel.
    start_phase();
    send_pixels(0, W * H, 1'b1, 1'b1);
    step(1'b0, 1'b0, 8'h00);
    check("gap_first_win", first_win, 72'h00_01_02_0a_0b_0c_14_15_16);
    check("gap_win_cnt", 72'(win_cnt), 72'd6);
    check("gap_fd_cnt", 72'(fd_cnt), 72'd1);

    // Asynchronous reset in the middle of row 2, then refeed.
    start_phase();
    send_pixels(0, 2 * W + 3, 1'b1, 1'b0);
    apply_reset();
    start_phase();
    send_pixels(0, W * H, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00);
    check("rst_first_win", first_win, 72'h00_01_02_0a_0b_0c_14_15_16);
    check("rst_win_cnt", 72'(win_cnt), 72'd6);

    // Frame A abandoned mid-row 1 by sof starting frame B.
    start_phase();
    send_pixels(200, W + 2, 1'b1, 1'b0);
    send_pixels(100, W * H, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00);
    check("sof_first_win", first_win, 72'h64_65_66_6e_6f_70_78_79_7a);
    check("sof_win_cnt", 72'(win_cnt), 72'd6);
    check("sof_fd_cnt", 72'(fd_cnt), 72'd1);

    // Two back-to-back frames without an idle cycle.
    start_phase();
    send_pixels(0, W * H, 1'b1, 1'b0);
    send_pixels(50, W * H, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    check("b2b_win_cnt", 72'(win_cnt), 72'd12);
    check("b2b_fd_cnt", 72'(fd_cnt), 72'd2);
    check("b2b_q_drained", 72'(exp_q.size()), 72'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sobel_window3x3.md
# sobel_window3x3

Raster-scan 3x3 window generator that sits directly upstream of the deterministic Sobel stage. It accepts one 8-bit grayscale pixel per valid cycle in row-major order. It buffers the two previous image rows in internal line buffers and presents the full 3x3 neighbourhood on `z1`..`z9`, with a `win_valid` qualifier. Windows are emitted only where all nine taps lie inside the image, so the Sobel stage never sees padded or stale data.

## Interface
- `IMG_W`, 64, image width in pixels; must be ≥ 3.
- `IMG_H`, 64, image height in lines; must be ≥ 3.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `pix_in`  in  8  input pixel.
- `pix_valid`  in  1  `pix_in` accepted this cycle when 1.
- `sof`  in  1  start of frame; sampled only when `pix_valid`=1; marks the pixel as (row 0, col 0).
- `z1`,`z2`,`z3`,`z4`,`z5`,`z6`,`z7`,`z8`,`z9`  out  8 each  window taps, row-major: `z1` top-left, `z5` centre, `z9` bottom-right.
- `win_valid`  out  1  taps form a complete in-image window.
- `frame_done`  out  1  one-cycle pulse; the last pixel (IMG_H-1, IMG_W-1) was accepted.

## Operation
- Counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1) have width `$clog2` of their parameter. They address the pixel being accepted.
- Accepted pixel with `sof`=1: treated as (0,0). Counters continue from (0,1).
- Otherwise the position is the current (`row`,`col`). After acceptance, `col` increments; at IMG_W-1 it wraps to 0 and `row` increments. At (IMG_H-1, IMG_W-1) both counters wrap to 0.
- Two line buffers, LB1 and LB2, each IMG_W×8 bits, indexed by `col`. They must use separate storage.
- On acceptance at column c, with a = LB1[c] and b = LB2[c] read before the write: LB2[c] ← a, LB1[c] ← `pix_in`.
- The window registers then shift left:
  - top row: z1←z2, z2←z3, z3←b
  - middle row: z4←z5, z5←z6, z6←a
  - bottom row: z7←z8, z8←z9, z9←`pix_in`
- Resulting window after pixel (r,c): z1..z3 = row r-2, columns c-2..c; z4..z6 = row r-1; z7..z9 = row r. The centre is (r-1, c-1).
- `win_valid` ← 1 iff a pixel was accepted with r ≥ 2 and c ≥ 2; otherwise 0. There are exactly (IMG_W-2)(IMG_H-2) windows per frame.
- `frame_done` ← 1 iff the accepted pixel was (IMG_H-1, IMG_W-1).
- `pix_valid`=0:
  - counters, line buffers and `z1`..`z9` hold;
  - `win_valid` and `frame_done` are 0 next cycle.
- Taps that cross a row boundary (c < 2) carry data from the previous row's end. They are never qualified by `win_valid`.
- Line-buffer contents are not reset. The r ≥ 2 gate guarantees no stale tap is ever qualified.

## Timing
- Reset (`reset`=0, asynchronous):
  - `z1`..`z9` = 8'h00, `win_valid` = 0, `frame_done` = 0;
  - `row` = 0, `col` = 0.
- After reset release, the next accepted pixel is (0,0) whether or not `sof` is asserted.
- Latency: 1 cycle. A pixel accepted at edge N produces its window and `win_valid` after edge N; the downstream stage registers it at edge N+1.
- Throughput: one pixel per cycle with no bubbles required. Gaps in `pix_valid` are allowed anywhere, including mid-row.
- `sof` mid-frame abandons the current frame. No `frame_done` is issued for it, and the first window of the new frame follows the new (2,2).
- Reset mid-frame: outputs clear immediately; the frame restarts as above.
- Back-to-back frames: the pixel after (IMG_H-1, IMG_W-1) is (0,0) of the next frame, with no idle cycle needed.

## Test plan
- IMG_W=5, IMG_H=4, continuous stream, pixel(r,c) = 10r+c:
  - after pixel (2,2): `win_valid`=1 with z1..z9 = 0,1,2,10,11,12,20,21,22;
  - exactly 6 `win_valid` pulses per frame;
  - `frame_done` once, in the cycle after pixel 34.
- Same frame with `pix_valid` toggled 1,0,1,0…: window values and count are identical; `win_valid` is never high in a cycle following `pix_valid`=0; taps hold during gaps.
- `reset`=0 asserted asynchronously mid-row 2:
  - outputs go to 0 before the next edge;
  - after release, the refed frame yields the first window 0,1,2,10,11,12,20,21,22 again.
- `sof` pulsed with a pixel mid-row 1 of frame A, then a full frame B of value 100+10r+c:
  - no `frame_done` for frame A;
  - frame B's first window = 100,101,102,110,111,112,120,121,122.
- Two back-to-back frames, no gap:
  - second frame's windows match the first (values offset as driven);
  - 12 total `win_valid` pulses and 2 `frame_done` pulses.
- Row-boundary check: no `win_valid` for pixels at columns 0 and 1 of any row, even though `z` taps change.
